// File: rtl/watch_timekeeper.sv
// watch_timekeeper
//
// Time base and counter stage for the watch display path.
//   - Prescaler divides clk into one-second periods. It provides a
//     50%-duty seconds_clk for blinking and a one-cycle sec_tick on the
//     last cycle of each second.
//   - 24-hour time-of-day counters with hour/minute setting through an
//     edge-detected increment button.
//   - 24-hour stopwatch counters with run/hold/clear controlled by the
//     mode code.
//
// Parameters:
//   CLK_DIV        clk cycles per second (even, >= 4)
//   SW_RUN_ALWAYS  1: stopwatch also counts in SHOW_STOPPED (3'b011)
//
// Optional build macro:
//   SET_CLR_SEC_EN  when defined, each minute increment in SET_M also
//                   clears the seconds counter.
//
// Ports:
//   clk          in   system clock, rising-edge active
//   reset        in   asynchronous, active-high reset
//   state [2:0]  in   mode code from watch_fsm
//   inc_btn      in   increment button (synchronous, debounced)
//   seconds_clk  out  high during the first half of each second
//   sec_tick     out  pulse on the last prescaler cycle of each second
//   current_s/m/h    out  time of day (0-59 / 0-59 / 0-23)
//   stopwatch_s/m/h  out  stopwatch (0-59 / 0-59 / 0-23)

module watch_timekeeper #(
    parameter int CLK_DIV       = 32768,
    parameter bit SW_RUN_ALWAYS = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] state,
    input  logic       inc_btn,
    output logic       seconds_clk,
    output logic       sec_tick,
    output logic [5:0] current_s,
    output logic [5:0] current_m,
    output logic [5:0] current_h,
    output logic [5:0] stopwatch_s,
    output logic [5:0] stopwatch_m,
    output logic [5:0] stopwatch_h
);

    // Mode codes driven by watch_fsm
    localparam logic [2:0] HIDE_STOPPED = 3'b000;
    localparam logic [2:0] SET_H        = 3'b001;
    localparam logic [2:0] SET_M        = 3'b010;
    localparam logic [2:0] SHOW_STOPPED = 3'b011;
    localparam logic [2:0] SHOW_RUNNING = 3'b100;
    localparam logic [2:0] SW_RESET     = 3'b101;
    localparam logic [2:0] HIDE_RUNNING = 3'b110;

    localparam int              CW       = $clog2(CLK_DIV);
    localparam logic [CW-1:0]   PRE_LAST = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0]   PRE_HALF = CW'(CLK_DIV / 2);

    localparam logic [5:0] MAX_SM = 6'd59;
    localparam logic [5:0] MAX_H  = 6'd23;

    // Increment with wrap to zero after max
    function automatic logic [5:0] wrap_inc(input logic [5:0] v,
                                            input logic [5:0] max);
        return (v == max) ? 6'd0 : v + 6'd1;
    endfunction

    // One-second advance of a packed {h, m, s} value; all carries resolve
    // together so 23:59:59 rolls straight to 00:00:00.
    function automatic logic [17:0] hms_advance(input logic [17:0] t);
        logic [5:0] h, m, s;
        {h, m, s} = t;
        if (s == MAX_SM) begin
            if (m == MAX_SM) begin
                h = wrap_inc(h, MAX_H);
            end
            m = wrap_inc(m, MAX_SM);
        end
        s = wrap_inc(s, MAX_SM);
        return {h, m, s};
    endfunction

    // ------------------------------------------------------------------
    // Prescaler: free-running in every mode
    // ------------------------------------------------------------------
    logic [CW-1:0] pre_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pre_cnt <= '0;
        end else if (pre_cnt == PRE_LAST) begin
            pre_cnt <= '0;
        end else begin
            pre_cnt <= pre_cnt + 1'b1;
        end
    end

    assign sec_tick    = (pre_cnt == PRE_LAST);
    assign seconds_clk = (pre_cnt < PRE_HALF);

    // ------------------------------------------------------------------
    // Increment button edge detect
    // ------------------------------------------------------------------
    logic inc_q;
    logic inc_pulse;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            inc_q <= 1'b0;
        end else begin
            inc_q <= inc_btn;
        end
    end

    assign inc_pulse = inc_btn & ~inc_q;

    // ------------------------------------------------------------------
    // Mode decode
    // ------------------------------------------------------------------
    logic tod_run;
    logic sw_run;
    logic sw_clear;

    always_comb begin
        tod_run  = 1'b0;
        sw_run   = 1'b0;
        sw_clear = 1'b0;
        case (state)
            HIDE_STOPPED: tod_run = 1'b1;
            SET_H:        tod_run = 1'b0;
            SET_M:        tod_run = 1'b0;
            SHOW_STOPPED: begin
                tod_run = 1'b1;
                sw_run  = SW_RUN_ALWAYS;
            end
            SHOW_RUNNING: begin
                tod_run = 1'b1;
                sw_run  = 1'b1;
            end
            SW_RESET: begin
                tod_run  = 1'b1;
                sw_clear = 1'b1;
            end
            HIDE_RUNNING: begin
                tod_run = 1'b1;
                sw_run  = 1'b1;
            end
            default: begin
                // Illegal code: every counter holds
                tod_run  = 1'b0;
                sw_run   = 1'b0;
                sw_clear = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Time of day
    // ------------------------------------------------------------------
    logic [17:0] tod_next;
    logic [17:0] tod_adv;

    assign tod_adv = hms_advance({current_h, current_m, current_s});

    always_comb begin
        tod_next = {current_h, current_m, current_s};
        if (tod_run && sec_tick) begin
            tod_next = tod_adv;
        end else if ((state == SET_H) && inc_pulse) begin
            tod_next[17:12] = wrap_inc(current_h, MAX_H);
        end else if ((state == SET_M) && inc_pulse) begin
            // Minute setting never carries into hours
            tod_next[11:6] = wrap_inc(current_m, MAX_SM);
`ifdef SET_CLR_SEC_EN
            tod_next[5:0]  = 6'd0;
`endif
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            current_h <= '0;
            current_m <= '0;
            current_s <= '0;
        end else begin
            {current_h, current_m, current_s} <= tod_next;
        end
    end

    // ------------------------------------------------------------------
    // Stopwatch
    // ------------------------------------------------------------------
    logic [17:0] sw_adv;

    assign sw_adv = hms_advance({stopwatch_h, stopwatch_m, stopwatch_s});

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stopwatch_h <= '0;
            stopwatch_m <= '0;
            stopwatch_s <= '0;
        end else if (sw_clear) begin
            stopwatch_h <= '0;
            stopwatch_m <= '0;
            stopwatch_s <= '0;
        end else if (sw_run && sec_tick) begin
            {stopwatch_h, stopwatch_m, stopwatch_s} <= sw_adv;
        end
    end

endmodule

// File: tb/tb_watch_timekeeper.sv
// Directed testbench for watch_timekeeper with CLK_DIV=4.
// Inputs change 1 time unit after each rising edge, and outputs are sampled at that same point.
// ph tracks the expected prescaler phase; with CLK_DIV=4 a tick occurs on
// every edge that leaves phase 3.

module tb_watch_timekeeper;

    logic       clk;
    logic       reset;
    logic [2:0] state;
    logic       inc_btn;
    logic       seconds_clk;
    logic       sec_tick;
    logic [5:0] current_s, current_m, current_h;
    logic [5:0] stopwatch_s, stopwatch_m, stopwatch_h;

    int checks = 0;
    int errors = 0;
    int ph     = 0;
    int nt;

`ifdef SET_CLR_SEC_EN
    localparam bit CLR = 1'b1;
`else
    localparam bit CLR = 1'b0;
`endif
    // Seconds value carried through the SET_M sequence
    localparam logic [5:0] S0    = CLR ? 6'd0 : 6'd3;
    localparam logic [5:0] S_SET = CLR ? 6'd0 : 6'd1;

    watch_timekeeper #(
        .CLK_DIV(4),
        .SW_RUN_ALWAYS(1'b0)
    ) dut (
        .clk(clk),
        .reset(reset),
        .state(state),
        .inc_btn(inc_btn),
        .seconds_clk(seconds_clk),
        .sec_tick(sec_tick),
        .current_s(current_s),
        .current_m(current_m),
        .current_h(current_h),
        .stopwatch_s(stopwatch_s),
        .stopwatch_m(stopwatch_m),
        .stopwatch_h(stopwatch_h)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout required finish");
        $fatal(1, "watchdog");
    end

    task automatic chk_b(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
        end
    endtask

    task automatic chk_i(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_t(input string tag, input logic [5:0] h,
                         input logic [5:0] m, input logic [5:0] s);
        checks++;
        assert ({current_h, current_m, current_s} === {h, m, s}) else begin
            errors++;
            $error("FAIL %s: observed tod %0d:%0d:%0d expected %0d:%0d:%0d",
                   tag, current_h, current_m, current_s, h, m, s);
        end
    endtask

    task automatic chk_w(input string tag, input logic [5:0] h,
                         input logic [5:0] m, input logic [5:0] s);
        checks++;
        assert ({stopwatch_h, stopwatch_m, stopwatch_s} === {h, m, s}) else begin
            errors++;
            $error("FAIL %s: observed sw %0d:%0d:%0d expected %0d:%0d:%0d",
                   tag, stopwatch_h, stopwatch_m, stopwatch_s, h, m, s);
        end
    endtask

    task automatic step(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            ph = (ph + 1) % 4;
        end
    endtask

    task automatic ticks(input int unsigned n);
        step(4 * n);
    endtask

    task automatic pulse(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) begin
            inc_btn = 1'b1;
            step(1);
            inc_btn = 1'b0;
            step(1);
        end
    endtask

    // Park in the illegal code (all counters hold) until phase 0
    task automatic align();
        state = 3'b111;
        while (ph != 0) step(1);
    endtask

    initial begin
        reset   = 1'b1;
        state   = 3'b000;
        inc_btn = 1'b0;
        #2;
        chk_t("reset_tod", 6'd0, 6'd0, 6'd0);
        chk_w("reset_sw", 6'd0, 6'd0, 6'd0);
        chk_b("reset_sclk", seconds_clk, 1'b1);
        chk_b("reset_tick", sec_tick, 1'b0);
        @(negedge clk);
        reset = 1'b0;

        // Prescaler pattern: counts 1,2,3,0
        step(1); chk_b("sclk_c1", seconds_clk, 1'b1); chk_b("tick_c1", sec_tick, 1'b0);
        step(1); chk_b("sclk_c2", seconds_clk, 1'b0); chk_b("tick_c2", sec_tick, 1'b0);
        step(1); chk_b("sclk_c3", seconds_clk, 1'b0); chk_b("tick_c3", sec_tick, 1'b1);
        step(1); chk_b("sclk_c4", seconds_clk, 1'b1); chk_b("tick_c4", sec_tick, 1'b0);
        chk_t("first_tick", 6'd0, 6'd0, 6'd1);

        // Hour setting and held-button single increment
        state = 3'b001;
        pulse(23);
        chk_t("set_h23", 6'd23, 6'd0, 6'd1);
        inc_btn = 1'b1;
        step(1);
        chk_t("hold_first", 6'd0, 6'd0, 6'd1);
        step(9);
        chk_t("hold_10", 6'd0, 6'd0, 6'd1);
        inc_btn = 1'b0;
        step(1);
        state = 3'b111;
        pulse(1);
        chk_t("illegal_inc", 6'd0, 6'd0, 6'd1);

        // Preload 23:59:58
        state = 3'b001;
        pulse(23);
        state = 3'b010;
        pulse(59);
        chk_t("set_m59", 6'd23, 6'd59, S_SET);
        align();
        state = 3'b000;
        ticks(CLR ? 58 : 57);
        chk_t("preload", 6'd23, 6'd59, 6'd58);
        ticks(1);
        chk_t("roll_59", 6'd23, 6'd59, 6'd59);
        ticks(1);
        chk_t("roll_00", 6'd0, 6'd0, 6'd0);

        // Minute set wrap without hour carry
        ticks(3);
        chk_t("run_3", 6'd0, 6'd0, 6'd3);
        state = 3'b001;
        pulse(5);
        state = 3'b010;
        pulse(59);
        chk_t("set_m_59h5", 6'd5, 6'd59, S0);
        pulse(1);
        chk_t("set_m_wrap", 6'd5, 6'd0, S0);

        // Stopwatch run / hold / clear
        align();
        state = 3'b100;
        ticks(61);
        chk_w("sw_61", 6'd0, 6'd1, 6'd1);
        chk_t("tod_61", 6'd5, 6'd1, S0 + 6'd1);
        state = 3'b011;
        ticks(5);
        chk_w("sw_hold", 6'd0, 6'd1, 6'd1);
        chk_t("tod_hold", 6'd5, 6'd1, S0 + 6'd6);
        state = 3'b101;
        step(1);
        chk_w("sw_clr1", 6'd0, 6'd0, 6'd0);
        step(3);
        chk_w("sw_clr4", 6'd0, 6'd0, 6'd0);
        chk_t("tod_in_clr", 6'd5, 6'd1, S0 + 6'd7);

        // Reset during a tick cycle
        state = 3'b100;
        ticks(2);
        chk_w("sw_2", 6'd0, 6'd0, 6'd2);
        chk_t("tod_pre_rst", 6'd5, 6'd1, S0 + 6'd9);
        step(3);
        chk_b("pre_rst_tick", sec_tick, 1'b1);
        reset = 1'b1;
        #1;
        chk_t("mid_rst_tod", 6'd0, 6'd0, 6'd0);
        chk_w("mid_rst_sw", 6'd0, 6'd0, 6'd0);
        chk_b("mid_rst_sclk", seconds_clk, 1'b1);
        chk_b("mid_rst_tick", sec_tick, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        ph = 0;

        // Illegal code holds counters, prescaler keeps running
        ticks(3);
        chk_t("post_rst_tod", 6'd0, 6'd0, 6'd3);
        chk_w("post_rst_sw", 6'd0, 6'd0, 6'd3);
        state = 3'b111;
        nt = 0;
        for (int i = 0; i < 32; i++) begin
            inc_btn = ((i % 3) == 0);
            step(1);
            if (sec_tick) nt++;
        end
        inc_btn = 1'b0;
        chk_i("illegal_ticks", nt, 8);
        chk_t("illegal_tod", 6'd0, 6'd0, 6'd3);
        chk_w("illegal_sw", 6'd0, 6'd0, 6'd3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
